// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encoding for the universal shift register.
package shift_pkg;
   localparam int MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
   localparam logic [MODE_W-1:0] MODE_SHL  = 3'd1;
   localparam logic [MODE_W-1:0] MODE_SHR  = 3'd2;
   localparam logic [MODE_W-1:0] MODE_ASHR = 3'd3;
   localparam logic [MODE_W-1:0] MODE_ROTL = 3'd4;
   localparam logic [MODE_W-1:0] MODE_ROTR = 3'd5;
   localparam logic [MODE_W-1:0] MODE_LOAD = 3'd6;

   // Only the serial shifts advance the frame counter.
   function automatic logic is_counted(input logic [MODE_W-1:0] m);
      return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ASHR);
   endfunction
endpackage

// File: rtl/univ_shift_reg_step_sync.sv
// Button synchroniser and rising-edge detector producing a one-cycle step pulse.
module step_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_step,
   output logic o_pulse
);
   logic       r_s1, r_s2, r_s3;
   logic [2:0] r_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_s3  <= 1'b0;
         r_vld <= 3'b000;
      end else begin
         r_s1  <= i_step;
         r_s2  <= r_s1;
         r_s3  <= r_s2;
         r_vld <= {r_vld[1:0], 1'b1};
      end
   end

   // r_vld tracks which stages hold real post-reset samples, so a button held
   // through reset is seen as already high rather than as a fresh edge.
   assign o_pulse = r_s2 & ~r_s3 & r_vld[2];
endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: shifts, rotates, parallel load, frame counter.
module univ_shift_reg
   import shift_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               STEP_SYNC = 1,
   parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      step,
   input  logic [MODE_W-1:0]         mode,
   input  logic                      sdin,
   input  logic [WIDTH-1:0]          pdin,
   output logic [WIDTH-1:0]          q,
   output logic                      sdout_msb,
   output logic                      sdout_lsb,
   output logic                      frame_done,
   output logic [$clog2(WIDTH)-1:0]  shift_cnt
);
   localparam int CNT_W = $clog2(WIDTH);

   logic [WIDTH-1:0] r_q;
   logic [CNT_W-1:0] r_cnt;
   logic             r_fd;
   logic             w_pulse;
   logic [WIDTH-1:0] w_q_nxt;

   generate
      if (STEP_SYNC != 0) begin : g_sync
         step_sync u_step_sync (
            .clk     (clk),
            .rst     (rst),
            .i_step  (step),
            .o_pulse (w_pulse)
         );
      end else begin : g_bypass
         assign w_pulse = step;
      end
   endgenerate

   always_comb begin
      w_q_nxt = r_q;
      case (mode)
         MODE_SHL:  w_q_nxt = {r_q[WIDTH-2:0], sdin};
         MODE_SHR:  w_q_nxt = {sdin, r_q[WIDTH-1:1]};
         MODE_ASHR: w_q_nxt = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
         MODE_ROTL: w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
         MODE_ROTR: w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
         MODE_LOAD: w_q_nxt = pdin;
         default:   w_q_nxt = r_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q   <= RST_VAL;
         r_cnt <= '0;
         r_fd  <= 1'b0;
      end else begin
         r_fd <= 1'b0;
         if (w_pulse) begin
            r_q <= w_q_nxt;
            if (mode == MODE_LOAD) begin
               r_cnt <= '0;
            end else if (is_counted(mode)) begin
               if (r_cnt == CNT_W'(WIDTH - 1)) begin
                  r_cnt <= '0;
                  r_fd  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         end
      end
   end

   assign q          = r_q;
   assign sdout_msb  = r_q[WIDTH-1];
   assign sdout_lsb  = r_q[0];
   assign frame_done = r_fd;
   assign shift_cnt  = r_cnt;
endmodule
